// File: rtl/spi_reg_bridge.sv
// SPI byte-protocol register bridge.
// Decodes command/address/data frames delimited by ss, maintains a small
// register file, drives LEDs from reg[0]/reg[1] and preloads tx_data with the
// next byte to shift back.
// Optional feature: define SPI_BRIDGE_ERRCNT_EN to turn reg[NREGS-1] into a
// read-only saturating error counter.
module spi_reg_bridge #(
   parameter int unsigned NREGS   = 8,
   parameter logic [7:0]  TX_IDLE = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ss,
   input  logic        rx_busy,
   input  logic [7:0]  rx_data,
   output logic [7:0]  tx_data,
   input  logic [15:0] switches,
   output logic [15:0] leds
);

   localparam int unsigned AddrW = $clog2(NREGS);

   typedef enum logic [1:0] {StIdle, StCmd, StWdata, StRdata} state_e;

   state_e             state_q, state_d;
   logic [AddrW-1:0]   addr_q, addr_d;
   logic [7:0]         cmd_q, cmd_d;
   logic [7:0]         tx_q, tx_d;
   logic [7:0]         regs_q [NREGS];
   logic [7:0]         regs_d [NREGS];
   logic               busy_q, ss_q;

   logic               byte_done, frame_start, frame_end;
   logic [AddrW-1:0]   rd_addr;
   logic [7:0]         rd_val;
   logic               wr_ro;

`ifdef SPI_BRIDGE_ERRCNT_EN
   logic [7:0]         errcnt_q, errcnt_d;
   logic               got_data_q, got_data_d;
   logic               err_inc;
`endif

   assign byte_done   = busy_q & ~rx_busy;
   assign frame_start = ss_q & ~ss;
   assign frame_end   = ~ss_q & ss;

   assign leds    = {regs_q[1], regs_q[0]};
   assign tx_data = tx_q;

   // Read address: command byte's address in CMD, otherwise the next burst address.
   assign rd_addr = (state_q == StCmd) ? rx_data[AddrW-1:0] : addr_q + AddrW'(1);

   // Read-back mux: switch registers and the error counter are not stored in regs_q.
   always_comb begin
      rd_val = regs_q[rd_addr];
      if (rd_addr == AddrW'(2)) rd_val = switches[7:0];
      if (rd_addr == AddrW'(3)) rd_val = switches[15:8];
`ifdef SPI_BRIDGE_ERRCNT_EN
      if (rd_addr == AddrW'(NREGS - 1)) rd_val = errcnt_q;
`endif
   end

   // Write protection for the current write address.
   always_comb begin
      wr_ro = (addr_q == AddrW'(2)) || (addr_q == AddrW'(3));
`ifdef SPI_BRIDGE_ERRCNT_EN
      if (addr_q == AddrW'(NREGS - 1)) wr_ro = 1'b1;
`endif
   end

   // Frame decoder: byte processing first, then frame delimiters override the state.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cmd_d   = cmd_q;
      tx_d    = tx_q;
      regs_d  = regs_q;
`ifdef SPI_BRIDGE_ERRCNT_EN
      got_data_d = got_data_q;
      err_inc    = 1'b0;
`endif
      if (byte_done) begin
         unique case (state_q)
            StCmd: begin
               addr_d = rx_data[AddrW-1:0];
               cmd_d  = rx_data;
               if (rx_data[7]) begin
                  state_d = StWdata;
                  tx_d    = rx_data;
`ifdef SPI_BRIDGE_ERRCNT_EN
                  got_data_d = 1'b0;
`endif
               end else begin
                  state_d = StRdata;
                  tx_d    = rd_val;
               end
            end
            StWdata: begin
               if (!wr_ro) regs_d[addr_q] = rx_data;
`ifdef SPI_BRIDGE_ERRCNT_EN
               else err_inc = 1'b1;
               got_data_d = 1'b1;
`endif
               addr_d = addr_q + AddrW'(1);
               tx_d   = cmd_q;
            end
            StRdata: begin
               addr_d = addr_q + AddrW'(1);
               tx_d   = rd_val;
            end
            default: ;
         endcase
      end
      if (frame_end) begin
`ifdef SPI_BRIDGE_ERRCNT_EN
         // Write command with no data byte at all counts as an error.
         if (state_q == StWdata && !got_data_q && !byte_done) err_inc = 1'b1;
`endif
         state_d = StIdle;
         tx_d    = TX_IDLE;
      end
      if (frame_start) state_d = StCmd;
   end

`ifdef SPI_BRIDGE_ERRCNT_EN
   // Saturating error counter.
   assign errcnt_d = (err_inc && errcnt_q != 8'hFF) ? errcnt_q + 8'd1 : errcnt_q;
`endif

   // State and register file with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         addr_q  <= '0;
         cmd_q   <= '0;
         tx_q    <= TX_IDLE;
         busy_q  <= 1'b0;
         ss_q    <= 1'b0;
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
`ifdef SPI_BRIDGE_ERRCNT_EN
         errcnt_q   <= '0;
         got_data_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cmd_q   <= cmd_d;
         tx_q    <= tx_d;
         busy_q  <= rx_busy;
         ss_q    <= ss;
         regs_q  <= regs_d;
`ifdef SPI_BRIDGE_ERRCNT_EN
         errcnt_q   <= errcnt_d;
         got_data_q <= got_data_d;
`endif
      end
   end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed self-checking bench for spi_reg_bridge (NREGS=8, TX_IDLE=8'hA5).
module tb_spi_reg_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        ss;
   logic        rx_busy;
   logic [7:0]  rx_data;
   logic [7:0]  tx_data;
   logic [15:0] switches;
   logic [15:0] leds;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0] m1, m2, m3;

   spi_reg_bridge #(
      .NREGS   (8),
      .TX_IDLE (8'hA5)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ss       (ss),
      .rx_busy  (rx_busy),
      .rx_data  (rx_data),
      .tx_data  (tx_data),
      .switches (switches),
      .leds     (leds)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One SPI byte; miso is the tx_data value presented when the transfer starts.
   task automatic send_byte(input logic [7:0] b, output logic [7:0] miso);
      @(negedge clk);
      miso    = tx_data;
      rx_busy = 1'b1;
      rx_data = b;
      tick(3);
      rx_busy = 1'b0;
      tick(2);
   endtask

   task automatic ss_low();
      @(negedge clk);
      ss = 1'b0;
      tick(2);
   endtask

   task automatic ss_high();
      @(negedge clk);
      ss = 1'b1;
      tick(2);
   endtask

   initial begin
      rst      = 1'b0;
      ss       = 1'b0;
      rx_busy  = 1'b0;
      rx_data  = 8'h00;
      switches = 16'h0000;
      tick(3);
      check("reset_leds", 32'(leds), 32'h0);
      check("reset_tx", 32'(tx_data), 32'hA5);

      // Frame already in progress at reset release is ignored.
      rst = 1'b1;
      tick(1);
      send_byte(8'h80, m1);
      send_byte(8'h12, m2);
      send_byte(8'h34, m3);
      check("stale_frame_leds", 32'(leds), 32'h0);
      check("stale_frame_tx", 32'(tx_data), 32'hA5);
      ss_high();

      // LED write burst with command echo.
      ss_low();
      send_byte(8'h80, m1);
      check("wr_echo_tx", 32'(tx_data), 32'h80);
      send_byte(8'h3C, m2);
      check("leds_after_b2", 32'(leds), 32'h003C);
      send_byte(8'hC3, m3);
      check("leds_after_b3", 32'(leds), 32'hC33C);
      check("echo_b2", 32'(m2), 32'h80);
      check("echo_b3", 32'(m3), 32'h80);
      ss_high();
      check("idle_tx", 32'(tx_data), 32'hA5);

      // Switch readback burst.
      switches = 16'hBEEF;
      ss_low();
      send_byte(8'h02, m1);
      send_byte(8'h00, m2);
      send_byte(8'h00, m3);
      check("sw_lo", 32'(m2), 32'hEF);
      check("sw_hi", 32'(m3), 32'hBE);
      ss_high();

      // Write at last address wraps to reg0.
      ss_low();
      send_byte(8'h87, m1);
      send_byte(8'h11, m2);
      send_byte(8'h22, m3);
      ss_high();
      check("wrap_leds", 32'(leds), 32'hC322);

      // Write to read-only switch register is dropped.
      ss_low();
      send_byte(8'h82, m1);
      send_byte(8'h55, m2);
      ss_high();
      ss_low();
      send_byte(8'h02, m1);
      send_byte(8'h00, m2);
      ss_high();
      check("ro_unchanged", 32'(m2), 32'hEF);

      // Write command without data, then read reg7 and wrap to reg0.
      ss_low();
      send_byte(8'h84, m1);
      ss_high();
      ss_low();
      send_byte(8'h07, m1);
      send_byte(8'h00, m2);
      send_byte(8'h00, m3);
      ss_high();
`ifdef SPI_BRIDGE_ERRCNT_EN
      check("reg7_errcnt", 32'(m2), 32'h03);
`else
      check("reg7_scratch", 32'(m2), 32'h11);
`endif
      check("rd_wrap_reg0", 32'(m3), 32'h22);

      // Scratch write then burst read.
      ss_low();
      send_byte(8'h85, m1);
      send_byte(8'hAB, m2);
      ss_high();
      ss_low();
      send_byte(8'h04, m1);
      send_byte(8'h00, m2);
      send_byte(8'h00, m3);
      ss_high();
      check("scratch4", 32'(m2), 32'h00);
      check("scratch5", 32'(m3), 32'hAB);

      // Data byte completes on the same cycle ss rises.
      ss_low();
      send_byte(8'h81, m1);
      @(negedge clk);
      rx_busy = 1'b1;
      rx_data = 8'h77;
      tick(3);
      rx_busy = 1'b0;
      ss      = 1'b1;
      tick(2);
      check("same_cycle_leds", 32'(leds), 32'h7722);
      check("same_cycle_tx", 32'(tx_data), 32'hA5);
      // Byte outside a frame is ignored.
      send_byte(8'h99, m1);
      check("idle_byte_leds", 32'(leds), 32'h7722);
      check("idle_byte_tx", 32'(tx_data), 32'hA5);

      // Reset mid-frame clears everything.
      ss_low();
      send_byte(8'h80, m1);
      @(negedge clk);
      rx_busy = 1'b1;
      rx_data = 8'h44;
      rst     = 1'b0;
      tick(2);
      rx_busy = 1'b0;
      tick(2);
      rst = 1'b1;
      tick(2);
      check("midreset_leds", 32'(leds), 32'h0);
      check("midreset_tx", 32'(tx_data), 32'hA5);
      ss_high();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
